// File: rtl/cpu_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, control FSM states and small op-class helpers.
package cpu_muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } md_state_e;

   // Divide class is encoded in funct3 bit 2.
   function automatic logic md_is_div(input md_op_e op);
      return op[2];
   endfunction

   // rs1 is treated as signed for MUL/MULH/MULHSU/DIV/REM.
   function automatic logic md_a_signed(input md_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   // rs2 is treated as signed for MUL/MULH/DIV/REM.
   function automatic logic md_b_signed(input md_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/cpu_muldiv.sv
// Iterative RV32M multiply/divide unit. Shift-add multiply and restoring
// divide share one 2*XLEN accumulator; operands are reduced to magnitudes
// at accept and the sign is restored in the FIX state.
module cpu_muldiv
   import cpu_muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CW = $clog2(XLEN) + 1;

   md_state_e         state_q;
   md_op_e            op_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   opnd_q;
   logic              neg_q;
   logic              neg_rem_q;
   logic [CW-1:0]     cnt_q;
   logic              busy_q;
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   md_op_e            op_in;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_abs;
   logic [XLEN-1:0]   b_abs;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   special_res;

   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_pr;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] prod_signed;
   logic [XLEN-1:0]   quo_signed;
   logic [XLEN-1:0]   rem_signed;
   logic [XLEN-1:0]   fix_res;

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

   // Operand conditioning at accept: magnitudes, sign flags, special cases.
   always_comb begin
      op_in       = md_op_e'(op);
      a_neg       = md_a_signed(op_in) && src_a[XLEN-1];
      b_neg       = md_b_signed(op_in) && src_b[XLEN-1];
      a_abs       = a_neg ? (~src_a + 1'b1) : src_a;
      b_abs       = b_neg ? (~src_b + 1'b1) : src_b;
      div_zero    = md_is_div(op_in) && (src_b == '0);
      div_ovf     = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                    (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);
      special_res = '0;
      if (div_zero) begin
         special_res = (op_in == MD_DIV || op_in == MD_DIVU) ? '1 : src_a;
      end else if (div_ovf) begin
         special_res = (op_in == MD_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
      end
   end

   // One iteration of each datapath plus the final sign correction.
   always_comb begin
      // Multiply: add multiplicand into the high half when the LSB is set, shift right.
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
      // Divide: shift in next dividend bit, trial-subtract divisor, keep if non-negative.
      div_pr   = acc_q[2*XLEN-1:XLEN-1];
      div_diff = div_pr - {1'b0, opnd_q};
      div_next = div_diff[XLEN] ? {div_pr[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0}
                                : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      prod_signed = neg_q ? (~acc_q + 1'b1) : acc_q;
      quo_signed  = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
      rem_signed  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
      unique case (op_q)
         MD_MUL:                         fix_res = prod_signed[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:   fix_res = prod_signed[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:                fix_res = quo_signed;
         default:                        fix_res = rem_signed;
      endcase
   end

   // Control FSM with registered busy/done/result and datapath state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         op_q      <= MD_MUL;
         acc_q     <= '0;
         opnd_q    <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start && !flush) begin
                  op_q      <= op_in;
                  neg_q     <= a_neg ^ b_neg;
                  neg_rem_q <= a_neg;
                  cnt_q     <= '0;
                  if (div_zero || div_ovf) begin
                     result_q <= special_res;
                     done_q   <= 1'b1;
                  end else begin
                     // Divide: acc = {remainder, dividend}; multiply: acc = {0, multiplier}.
                     acc_q   <= {{XLEN{1'b0}}, md_is_div(op_in) ? a_abs : b_abs};
                     opnd_q  <= md_is_div(op_in) ? b_abs : a_abs;
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (flush) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q <= md_is_div(op_q) ? div_next : mul_next;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == CW'(XLEN - 1)) begin
                     state_q <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               if (!flush) begin
                  result_q <= fix_res;
                  done_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_muldiv.sv
// Directed self-checking bench for cpu_muldiv with hand-computed results.
module tb_cpu_muldiv;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   cpu_muldiv #(.XLEN(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Advance to the next cycle, sampling 1 time unit after the edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue op in the current cycle (cycle 0); check busy/done every cycle up to done.
   // Returns in the done cycle so the caller can issue back-to-back.
   task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      for (int c = 1; c <= lat; c++) begin
         next_cycle();
         if (c == 1) start = 1'b0;
         chk($sformatf("%s busy c%0d", tag, c), {63'd0, busy}, {63'd0, c < lat});
         chk($sformatf("%s done c%0d", tag, c), {63'd0, done}, {63'd0, c == lat});
      end
      chk($sformatf("%s result", tag), {32'd0, result}, {32'd0, exp});
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      flush = 1'b0;
      op    = 3'd0;
      src_a = '0;
      src_b = '0;
      repeat (3) next_cycle();
      chk("rst busy",   {63'd0, busy},   64'd0);
      chk("rst done",   {63'd0, done},   64'd0);
      chk("rst result", {32'd0, result}, 64'd0);
      rst_n = 1'b1;
      next_cycle();

      // 1: MUL 7 * -3 = -21, full latency and busy profile
      do_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
      next_cycle();
      chk("mul done pulse", {63'd0, done}, 64'd0);

      // 2: high-half sign cases
      do_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
      do_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
      do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);

      // 3: divide/remainder signs, back-to-back
      do_op("div",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
      do_op("rem",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
      do_op("divu", 3'd5, 32'd100, 32'd7, 32'd14, 34);
      do_op("remu", 3'd7, 32'd100, 32'd7, 32'd2, 34);

      // 5: DIVU flushed in cycle 10; start while busy ignored; result holds 2
      start = 1'b1; op = 3'd5; src_a = 32'd1000; src_b = 32'd3;
      for (int c = 1; c <= 40; c++) begin
         next_cycle();
         if (c == 1) start = 1'b0;
         if (c == 5) begin
            start = 1'b1; op = 3'd4; src_a = 32'd1; src_b = 32'd0;
         end
         if (c == 6) start = 1'b0;
         if (c == 10) flush = 1'b1;
         if (c == 11) begin
            flush = 1'b0;
            chk("flush busy c11", {63'd0, busy}, 64'd0);
         end
         if (c == 9) chk("flush busy c9", {63'd0, busy}, 64'd1);
         if (done) chk($sformatf("flush done c%0d", c), {63'd0, done}, 64'd0);
      end
      chk("flush result hold", {32'd0, result}, 64'd2);

      // flush and start together in IDLE: start dropped
      start = 1'b1; flush = 1'b1; op = 3'd4; src_a = 32'd5; src_b = 32'd0;
      next_cycle();
      start = 1'b0; flush = 1'b0;
      chk("flush+start done", {63'd0, done}, 64'd0);
      chk("flush+start busy", {63'd0, busy}, 64'd0);
      chk("flush+start result", {32'd0, result}, 64'd2);

      // 4: special cases bypass RUN, back-to-back
      do_op("div0",   3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      do_op("remu0",  3'd7, 32'd5, 32'd0, 32'd5, 1);
      do_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      // leave a non-zero result so the reset clear is visible
      do_op("divu0",  3'd5, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
      next_cycle();

      // 6: reset mid-MUL
      start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd4;
      for (int c = 1; c <= 40; c++) begin
         next_cycle();
         if (c == 1) start = 1'b0;
         if (c == 5) rst_n = 1'b0;
         if (c == 6) begin
            rst_n = 1'b1;
            chk("rst mid busy",   {63'd0, busy},   64'd0);
            chk("rst mid done",   {63'd0, done},   64'd0);
            chk("rst mid result", {32'd0, result}, 64'd0);
         end
         if (c > 6 && done) chk($sformatf("rst late done c%0d", c), {63'd0, done}, 64'd0);
      end
      chk("rst final result", {32'd0, result}, 64'd0);
      chk("rst final busy",   {63'd0, busy},   64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
